// File: rtl/regfile_scan_param.sv
// -----------------------------------------------------------------------------
// regfile_scan_param
//   Parametrised register file for the single-cycle datapath. It has
//   NREGS x DATA_W entries, two combinational read ports and one synchronous
//   write port. Register 0 always reads as zero. When FWD=1, a read of the
//   register being written in the same cycle returns the incoming write data.
//   A serial dump sequencer streams every register, index 0..NREGS-1, to the
//   LCD driver over a valid/ready channel.
//
// Ports
//   CLK        in   1       clock, rising edge
//   RST        in   1       synchronous active-high reset
//   we3        in   1       write enable
//   wa3        in   ADDR_W  write address
//   wd3        in   DATA_W  write data
//   ra1        in   ADDR_W  read address, port 1
//   ra2        in   ADDR_W  read address, port 2
//   rd1        out  DATA_W  read data, port 1 (combinational)
//   rd2        out  DATA_W  read data, port 2 (combinational)
//   dump_start in   1       pulse: begin streaming all registers
//   dump_ready in   1       consumer accepts the current beat
//   dump_valid out  1       beat on dump_addr/dump_data is valid
//   dump_addr  out  ADDR_W  index of the register being streamed
//   dump_data  out  DATA_W  live value of register dump_addr
//   dump_last  out  1       current beat is index NREGS-1
//   dump_busy  out  1       sequencer is not IDLE (mirrors the FSM state)
//
// Handshake: a beat transfers on a rising CLK edge where dump_valid and
// dump_ready are both 1. While dump_valid is high, dump_addr holds until
// the beat transfers. dump_data is not registered: it follows the register
// contents, so a write to that register during a stall appears on
// dump_data. The consumer may drive dump_ready freely.
// -----------------------------------------------------------------------------
module regfile_scan_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 9,
  parameter int FWD    = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              dump_busy
);

  // One extra bit lets the comparison cover NREGS == 2**ADDR_W.
  localparam logic [ADDR_W:0]   NREGS_W   = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_regs [NREGS];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_dump_addr;
  logic [ADDR_W-1:0] w_dump_addr_nxt;
  logic              w_wr_en;
  logic              w_rd1_ok;
  logic              w_rd2_ok;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  // A write to $0 or to an index past the last register is dropped here.
  // Entry 0 therefore stays at its reset value of zero.
  assign w_wr_en = we3 && (wa3 != '0) && ({1'b0, wa3} < NREGS_W);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[wa3] <= wd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  assign w_rd1_ok = (ra1 != '0) && ({1'b0, ra1} < NREGS_W);
  assign w_rd2_ok = (ra2 != '0) && ({1'b0, ra2} < NREGS_W);

  // The write-first bypass uses w_wr_en, so ignored writes are never
  // forwarded.
  always_comb begin
    rd1 = '0;
    if (w_rd1_ok) begin
      if ((FWD != 0) && w_wr_en && (ra1 == wa3)) rd1 = wd3;
      else                                       rd1 = r_regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (w_rd2_ok) begin
      if ((FWD != 0) && w_wr_en && (ra2 == wa3)) rd2 = wd3;
      else                                       rd2 = r_regs[ra2];
    end
  end

  // ---------------------------------------------------------------------------
  // Dump sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_dump_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_dump_addr <= w_dump_addr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Dump sequencer: next-state logic
  // ---------------------------------------------------------------------------
  // In SEND, dump_start is not examined. A start pulse during a dump
  // therefore has no effect.
  always_comb begin
    w_state_nxt     = r_state;
    w_dump_addr_nxt = r_dump_addr;
    case (r_state)
      S_IDLE: begin
        if (dump_start) begin
          w_state_nxt     = S_SEND;
          w_dump_addr_nxt = '0;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (r_dump_addr == LAST_ADDR) begin
            w_state_nxt     = S_IDLE;
            w_dump_addr_nxt = '0;
          end else begin
            w_dump_addr_nxt = r_dump_addr + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_dump_addr_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dump sequencer: outputs
  // ---------------------------------------------------------------------------
  // dump_data reads storage directly, with no bypass. It shows the current
  // register contents, not an in-flight write.
  always_comb begin
    dump_valid = (r_state == S_SEND);
    dump_busy  = (r_state != S_IDLE);
    dump_addr  = r_dump_addr;
    dump_last  = (r_state == S_SEND) && (r_dump_addr == LAST_ADDR);
    dump_data  = r_regs[r_dump_addr];
  end

endmodule

// File: tb/tb_regfile_scan_param.sv
module tb_regfile_scan_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 9;

  logic              CLK;
  logic              RST;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              dump_start;
  logic              dump_ready;

  logic [DATA_W-1:0] rd1, rd2;
  logic              dump_valid, dump_last, dump_busy;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  logic [DATA_W-1:0] nf_rd1, nf_rd2;
  logic              nf_dump_valid, nf_dump_last, nf_dump_busy;
  logic [ADDR_W-1:0] nf_dump_addr;
  logic [DATA_W-1:0] nf_dump_data;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  regfile_scan_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .FWD(1)) u_dut (
    .CLK(CLK), .RST(RST), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
    .dump_busy(dump_busy)
  );

  // Second instance with forwarding disabled, sharing all inputs.
  regfile_scan_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .FWD(0)) u_dut_nofwd (
    .CLK(CLK), .RST(RST), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(nf_rd1), .rd2(nf_rd2),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(nf_dump_valid),
    .dump_addr(nf_dump_addr), .dump_data(nf_dump_data), .dump_last(nf_dump_last),
    .dump_busy(nf_dump_busy)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Driver / scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s: observed=%h but expected queue is empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  function automatic logic [31:0] beat(input int a, input int d, input bit l);
    logic [31:0] v;
    v = 32'(((a & 15) << 9) | ((d & 255) << 1) | int'(l));
    return v;
  endfunction

  function automatic logic [31:0] obs_beat();
    return beat(int'(dump_addr), int'(dump_data), dump_last);
  endfunction

  function automatic logic [31:0] obs_status();
    return {27'd0, dump_valid, dump_busy, dump_last, 2'b00} | 32'(dump_addr) << 8;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    int beats;
    n_checks   = 0;
    n_errors   = 0;
    RST        = 1'b1;
    we3        = 1'b0;
    wa3        = '0;
    wd3        = '0;
    ra1        = '0;
    ra2        = '0;
    dump_start = 1'b0;
    dump_ready = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    settle();

    // 1. Reset state: every address reads 0, sequencer idle.
    push_exp(32'h0);
    check_pop("reset_status", obs_status());
    for (int a = 0; a < 16; a++) begin
      ra1 = 4'(a);
      ra2 = 4'(15 - a);
      settle();
      push_exp(32'h0);
      check_pop($sformatf("reset_rd_%0d", a), {8'h0, rd1, rd2, nf_rd1});
    end

    // 2. Basic write then read; writes to $0 are dropped.
    we3 = 1'b1; wa3 = 4'd3; wd3 = 8'hA5;
    tick();
    we3 = 1'b0; ra1 = 4'd3;
    settle();
    push_exp(32'hA5A5);
    check_pop("wr3_rd1", {16'h0, rd1, nf_rd1});
    we3 = 1'b1; wa3 = 4'd0; wd3 = 8'hFF; ra1 = 4'd0;
    settle();
    push_exp(32'h0);
    check_pop("wr0_fwd_blocked", {24'h0, rd1});
    tick();
    we3 = 1'b0; ra2 = 4'd0;
    settle();
    push_exp(32'h0);
    check_pop("wr0_rd2", {16'h0, rd2, nf_rd2});

    // 3. Same-cycle forwarding: FWD=1 gives new data, FWD=0 gives old data.
    we3 = 1'b1; wa3 = 4'd5; wd3 = 8'h3C; ra1 = 4'd5; ra2 = 4'd5;
    settle();
    push_exp(32'h3C3C0000);
    check_pop("fwd_same_cycle", {rd1, rd2, nf_rd1, nf_rd2});
    tick();
    we3 = 1'b0;
    settle();
    push_exp(32'h3C3C3C3C);
    check_pop("fwd_after_edge", {rd1, rd2, nf_rd1, nf_rd2});

    // 4. Out-of-range writes are ignored and out-of-range reads return 0.
    we3 = 1'b1; wa3 = 4'd9; wd3 = 8'h12; ra1 = 4'd9;
    settle();
    push_exp(32'h0);
    check_pop("wr9_fwd_blocked", {24'h0, rd1});
    tick();
    wa3 = 4'd15; wd3 = 8'h34;
    tick();
    we3 = 1'b0; ra1 = 4'd9; ra2 = 4'd15;
    settle();
    push_exp(32'h0);
    check_pop("rd_out_of_range", {rd1, rd2, nf_rd1, nf_rd2});
    ra1 = 4'd8;
    settle();
    push_exp(32'h0);
    check_pop("rd8_untouched", {24'h0, rd1});

    // 5. Load reg[i] = i*16+1, then a full dump with ready held high.
    for (int i = 1; i < NREGS; i++) begin
      we3 = 1'b1; wa3 = 4'(i); wd3 = 8'(i * 16 + 1);
      tick();
    end
    we3 = 1'b0;
    push_exp(beat(0, 0, 1'b0));
    for (int i = 1; i < NREGS; i++) push_exp(beat(i, i * 16 + 1, i == NREGS - 1));
    dump_start = 1'b1; dump_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    cnt   = 1;
    beats = 0;
    while (dump_busy && cnt < 50) begin
      if (dump_valid && dump_ready) begin
        check_pop($sformatf("dump_beat_%0d", beats), obs_beat());
        beats++;
      end
      // A start pulse in mid-stream must not restart the dump.
      dump_start = (cnt == 5);
      tick();
      cnt++;
    end
    dump_start = 1'b0;
    push_exp(32'(NREGS + 1));
    check_pop("dump_latency", 32'(cnt));
    push_exp(32'(NREGS));
    check_pop("dump_beat_count", 32'(beats));
    push_exp(32'h0);
    check_pop("dump_leftover", 32'(exp_q.size() - 1));
    push_exp(32'h0);
    check_pop("idle_after_dump", obs_status());

    // 6. Stall at addr 2, write reg2 during the stall, then reset mid-dump.
    dump_start = 1'b1; dump_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    push_exp(beat(0, 0, 1'b0));
    check_pop("stall_beat0", obs_beat());
    dump_ready = 1'b1;
    tick();
    tick();
    dump_ready = 1'b0;
    settle();
    push_exp(beat(2, 8'h21, 1'b0));
    check_pop("stall_c1", obs_beat());
    we3 = 1'b1; wa3 = 4'd2; wd3 = 8'h77;
    settle();
    push_exp(beat(2, 8'h21, 1'b0));
    check_pop("stall_no_fwd", obs_beat());
    tick();
    we3 = 1'b0;
    push_exp(beat(2, 8'h77, 1'b0));
    check_pop("stall_c2", obs_beat());
    tick();
    push_exp(beat(2, 8'h77, 1'b0));
    check_pop("stall_c3", obs_beat());
    push_exp(32'h1);
    check_pop("stall_valid", {31'h0, dump_valid});
    dump_ready = 1'b1;
    tick();
    push_exp(beat(3, 8'h31, 1'b0));
    check_pop("resume_beat3", obs_beat());
    RST = 1'b1; we3 = 1'b1; wa3 = 4'd4; wd3 = 8'h99; dump_start = 1'b1;
    tick();
    RST = 1'b0; we3 = 1'b0; dump_start = 1'b0;
    settle();
    push_exp(32'h0);
    check_pop("rst_mid_dump", obs_status());
    ra1 = 4'd4; ra2 = 4'd2;
    settle();
    push_exp(32'h0);
    check_pop("rst_clears_regs", {rd1, rd2, nf_rd1, nf_rd2});
    tick();
    push_exp(32'h0);
    check_pop("rst_start_dropped", obs_status());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
